// File: rtl/leds_pkg.sv
// rtl/leds_pkg.sv - shared constants and helpers for the LED scanner/fader blocks
package leds_pkg;

   localparam int CHANNELS_DEF    = 8;
   localparam int PWM_BITS_DEF    = 8;
   localparam int DECAY_TICKS_DEF = 50_000;
   localparam int DECAY_STEP_DEF  = 16;

   // Full-brightness level for a given level width.
   function automatic int level_max(input int bits);
      return (1 << bits) - 1;
   endfunction

   // Last value the PWM counter reaches before wrapping (period = level_max).
   function automatic int pwm_max(input int bits);
      return (1 << bits) - 2;
   endfunction

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/leds_tick_gen.sv
// rtl/leds_tick_gen.sv - free-running prescaler producing a one-cycle tick every TICKS cycles
module leds_tick_gen
   import leds_pkg::*;
#(
   parameter int TICKS = DECAY_TICKS_DEF
)(
   input  logic clock,
   input  logic reset_n,
   input  logic enable,
   output logic tick
);

   localparam int            CW   = cnt_width(TICKS);
   localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

   logic [CW-1:0] tick_cnt;

   assign tick = enable & (tick_cnt == LAST);

   // Count 0..TICKS-1 and wrap; parked at 0 while disabled so restart is aligned.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt <= '0;
      end else if (!enable) begin
         tick_cnt <= '0;
      end else if (tick_cnt == LAST) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/leds_trail_fader.sv
// rtl/leds_trail_fader.sv - per-LED brightness with saturating decay, rendered by a shared PWM counter
module leds_trail_fader
   import leds_pkg::*;
#(
   parameter int CHANNELS    = CHANNELS_DEF,
   parameter int PWM_BITS    = PWM_BITS_DEF,
   parameter int DECAY_TICKS = DECAY_TICKS_DEF,
   parameter int DECAY_STEP  = DECAY_STEP_DEF
)(
   input  logic                clock,
   input  logic                reset_n,
   input  logic                enable,
   input  logic [CHANNELS-1:0] leds_in,
   output logic [CHANNELS-1:0] leds_out,
   output logic                pwm_period_start
);

   localparam logic [PWM_BITS-1:0] LEVEL_MAX = PWM_BITS'(level_max(PWM_BITS));
   localparam logic [PWM_BITS-1:0] PWM_LAST  = PWM_BITS'(pwm_max(PWM_BITS));
   localparam logic [PWM_BITS-1:0] STEP      = PWM_BITS'(DECAY_STEP);

   logic [CHANNELS-1:0] leds_in_q;
   logic [CHANNELS-1:0] above_cnt;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                decay_tick;

   leds_tick_gen #(
      .TICKS (DECAY_TICKS)
   ) u_decay_tick (
      .clock   (clock),
      .reset_n (reset_n),
      .enable  (enable),
      .tick    (decay_tick)
   );

   // Register the scanner pattern once before it drives the level logic.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         leds_in_q <= '0;
      end else begin
         leds_in_q <= leds_in;
      end
   end

   // Shared PWM counter 0..LEVEL_MAX-1; held at 0 while disabled.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pwm_cnt <= '0;
      end else if (!enable) begin
         pwm_cnt <= '0;
      end else if (pwm_cnt == PWM_LAST) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [PWM_BITS-1:0] level;

      // Lit input wins over a coincident decay tick; decay saturates at 0.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            level <= '0;
         end else if (!enable) begin
            level <= '0;
         end else if (leds_in_q[i]) begin
            level <= LEVEL_MAX;
         end else if (decay_tick) begin
            level <= (level > STEP) ? (level - STEP) : '0;
         end
      end

      assign above_cnt[i] = (level > pwm_cnt);
   end

   // Registered LED drive and period-start pulse; both forced low while disabled.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         leds_out         <= '0;
         pwm_period_start <= 1'b0;
      end else begin
         leds_out         <= enable ? above_cnt : '0;
         pwm_period_start <= enable & (pwm_cnt == '0);
      end
   end

endmodule

// File: tb/tb_leds_trail_fader.sv
// tb/tb_leds_trail_fader.sv - directed self-checking bench for leds_trail_fader
module tb_leds_trail_fader;

   logic       clock;
   logic       reset_n;
   logic       enable;
   logic [7:0] leds_in;
   logic [7:0] leds_out;
   logic       pwm_period_start;

   int n_vec = 0;
   int n_bad = 0;
   int k;

   leds_trail_fader #(
      .CHANNELS    (8),
      .PWM_BITS    (4),
      .DECAY_TICKS (8),
      .DECAY_STEP  (4)
   ) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .enable           (enable),
      .leds_in          (leds_in),
      .leds_out         (leds_out),
      .pwm_period_start (pwm_period_start)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle; k is the index of the edge just taken.
   task automatic step();
      @(posedge clock);
      #1;
      k = k + 1;
   endtask

   // Clear levels and counters via enable, then restart with pattern pat before edge 0.
   task automatic rebase(input logic [7:0] pat);
      enable  = 1'b0;
      leds_in = 8'h00;
      step();
      step();
      leds_in = pat;
      enable  = 1'b1;
      k       = -1;
   endtask

   logic [47:0] tr;
   logic [47:0] ptr;
   logic [7:0]  acc;
   logic [7:0]  acc2;
   logic        pacc;
   int          cnt;
   int          sweep_k [11] = '{20, 27, 30, 32, 33, 36, 38, 42, 45, 47, 48};
   logic [7:0]  sweep_v [11] = '{8'h07, 8'h0C, 8'h0F, 8'h0F, 8'h0E, 8'h0E,
                                 8'h0C, 8'h00, 8'h0E, 8'h0E, 8'h08};

   initial begin
      reset_n = 1'b0;
      enable  = 1'b1;
      leds_in = 8'hFF;
      k       = 0;

      // Reset held with all inputs lit, then release.
      repeat (3) @(posedge clock);
      #1;
      check("rst_out", leds_out, 8'h00);
      check("rst_pps", pwm_period_start, 1'b0);
      reset_n = 1'b1;
      k = -1;
      step();
      check("rel_e0_out", leds_out, 8'h00);
      check("rel_e0_pps", pwm_period_start, 1'b1);
      step();
      check("rel_e1_out", leds_out, 8'h00);
      check("rel_e1_pps", pwm_period_start, 1'b0);
      step();
      check("rel_e2_out", leds_out, 8'hFF);
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         if (leds_out === 8'hFF) cnt++;
         if (i < 14) step();
      end
      check("rel_full_period", cnt, 15);

      // Single one-cycle pulse on bit 0: 15 -> 11 -> 7 -> 3 -> 0.
      rebase(8'h01);
      step();
      leds_in = 8'h00;
      tr = '0; ptr = '0; acc = '0;
      tr[0] = leds_out[0]; ptr[0] = pwm_period_start; acc = acc | {leds_out[7:1], 1'b0};
      while (k < 47) begin
         step();
         tr[k]  = leds_out[0];
         ptr[k] = pwm_period_start;
         acc    = acc | {leds_out[7:1], 1'b0};
      end
      check("pulse_trace", tr, 48'h0000_C03F_87FC);
      check("pulse_pps", ptr, 48'h2000_4000_8001);
      check("pulse_other_bits", acc, 8'h00);
      acc = '0;
      while (k < 70) begin
         step();
         acc = acc | leds_out;
      end
      check("pulse_tail_dark", acc, 8'h00);

      // Bit 3 held across three decay ticks, dropped after edge 30.
      rebase(8'h08);
      step();
      tr = '0; acc = '0;
      tr[0] = leds_out[3];
      while (k < 47) begin
         if (k == 30) leds_in = 8'h00;
         step();
         tr[k] = leds_out[3];
         acc   = acc | {4'h0, leds_out[2:0], 1'b0} | {leds_out[7:4], 4'h0};
      end
      check("collide_trace", tr, 48'hE1FF_FFFF_FFFC);
      check("collide_other_bits", acc, 8'h00);

      // One-hot sweep 01 -> 08, eight cycles per position, then dark.
      rebase(8'h01);
      acc = '0; acc2 = '0;
      for (int e = 0; e <= 90; e++) begin
         step();
         for (int j = 0; j < 11; j++)
            if (k == sweep_k[j]) check($sformatf("sweep_k%0d", k), leds_out, sweep_v[j]);
         acc = acc | {leds_out[7:4], 4'h0};
         if (k >= 64) acc2 = acc2 | leds_out;
         leds_in = (k + 1 < 32) ? (8'h01 << ((k + 1) / 8)) : 8'h00;
      end
      check("sweep_upper_dark", acc, 8'h00);
      check("sweep_floor", acc2, 8'h00);

      // Disable mid-decay (level 7), then re-enable with no input.
      rebase(8'h01);
      step();
      leds_in = 8'h00;
      while (k < 17) step();
      check("en_pre_out", leds_out, 8'h01);
      enable = 1'b0;
      step();
      check("en_off_out", leds_out, 8'h00);
      check("en_off_pps", pwm_period_start, 1'b0);
      acc = '0; pacc = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         acc  = acc | leds_out;
         pacc = pacc | pwm_period_start;
      end
      check("en_off_hold_out", acc, 8'h00);
      check("en_off_hold_pps", pacc, 1'b0);
      enable = 1'b1;
      step();
      check("reen_first_pps", pwm_period_start, 1'b1);
      acc = leds_out; pacc = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         step();
         acc = acc | leds_out;
         if (i < 15) pacc = pacc | pwm_period_start;
         else check("reen_next_pps", pwm_period_start, 1'b1);
      end
      check("reen_gap_pps", pacc, 1'b0);
      check("reen_dark", acc, 8'h00);

      // Asynchronous reset asserted between edges while a channel is fading.
      rebase(8'h01);
      step();
      leds_in = 8'h00;
      while (k < 15) step();
      check("ar_pre_out", leds_out, 8'h01);
      check("ar_pre_pps", pwm_period_start, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check("ar_async_out", leds_out, 8'h00);
      check("ar_async_pps", pwm_period_start, 1'b0);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      acc = '0;
      for (int i = 0; i < 40; i++) begin
         step();
         acc = acc | leds_out;
      end
      check("ar_after_dark", acc, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
